// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780-style line reader: the
//               controller state encoding, LCD command/ASCII constants and
//               the character decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Controller states, explicitly encoded so the width is fixed at 3 bits.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_ADDR  = 3'd1,
    POLL_BF   = 3'd2,
    READ_CHAR = 3'd3,
    DONE      = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] LCD_LINE2_BASE = 8'h40;
  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_ONE      = 8'h31;

  // Returns {error, bit}: '1' -> 1, '0' -> 0, anything else -> 0 with error.
  function automatic logic [1:0] decode_char(input logic [7:0] c);
    if (c == ASCII_ONE) begin
      return 2'b01;
    end else if (c == ASCII_ZERO) begin
      return 2'b00;
    end else begin
      return 2'b10;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_cycle
// Description : Generates the EN timing of one LCD bus cycle: one setup
//               cycle (EN low), EN_HIGH_CYCLES cycles with EN high, one hold
//               cycle (EN low). Cycles repeat back-to-back while i_run is
//               held high.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_run        - a bus cycle is wanted (controller in bus state)
//               o_en         - LCD EN pin
//               o_sample     - last EN-high cycle; read data is captured here
//               o_done       - hold cycle; the bus cycle completes at its end
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_cycle #(
  parameter int EN_HIGH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_en,
  output logic o_sample,
  output logic o_done
);

  localparam int PW = $clog2(EN_HIGH_CYCLES + 2);
  localparam logic [PW-1:0] c_LAST_EN = PW'(EN_HIGH_CYCLES);
  localparam logic [PW-1:0] c_HOLD    = PW'(EN_HIGH_CYCLES + 1);

  // Phase 0 = setup, 1..EN_HIGH_CYCLES = EN high, EN_HIGH_CYCLES+1 = hold.
  logic [PW-1:0] r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (!i_run || (r_phase == c_HOLD)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  assign o_en     = (r_phase != '0) && (r_phase <= c_LAST_EN);
  assign o_sample = i_run && (r_phase == c_LAST_EN);
  assign o_done   = i_run && (r_phase == c_HOLD);

endmodule
`default_nettype wire

// File: rtl/read_from_lcd.sv
`default_nettype none
// ============================================================================
// Module      : read_from_lcd
// Description : Reads one 16-character line from an HD44780-style LCD and
//               decodes the ASCII '0'/'1' characters into a 16-bit word
//               (first character = MSB). Sets the DDRAM address, polls the
//               busy flag (bounded by BF_TIMEOUT) and then performs 16 data
//               reads relying on the panel's address auto-increment.
// Ports       : clock, reset       - clock, asynchronous active-low reset
//               start, line_select - request (1 cycle) and line 0/1 select
//               lcd_data_in        - bus as driven by the panel
//               lcd_data_out, data_oe, enable, rs, rw - LCD bus control
//               word_out, word_valid - decoded line and completion strobe
//               busy, decode_error, timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module read_from_lcd
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYCLES = 2,
  parameter int BF_TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        line_select,
  input  logic [7:0]  lcd_data_in,
  output logic [7:0]  lcd_data_out,
  output logic        data_oe,
  output logic        enable,
  output logic        rs,
  output logic        rw,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        busy,
  output logic        decode_error,
  output logic        timeout
);

  localparam int PCW = (BF_TIMEOUT < 2) ? 1 : $clog2(BF_TIMEOUT);
  localparam logic [PCW-1:0] c_POLL_LAST = PCW'(BF_TIMEOUT - 1);

  lcd_state_e     r_state;
  logic           r_line;
  logic           r_bf;
  logic [PCW-1:0] r_polls;
  logic [3:0]     r_char;
  logic [15:0]    r_shift;
  logic [15:0]    r_word;
  logic           r_derr;
  logic           r_tout;

  logic       w_run;
  logic       w_sample;
  logic       w_done;
  logic [1:0] w_char;

  assign w_run  = (r_state == SET_ADDR) || (r_state == POLL_BF) ||
                  (r_state == READ_CHAR);
  assign w_char = decode_char(lcd_data_in);

  lcd_bus_cycle #(
    .EN_HIGH_CYCLES(EN_HIGH_CYCLES)
  ) u_bus (
    .clk      (clock),
    .rst_n    (reset),
    .i_run    (w_run),
    .o_en     (enable),
    .o_sample (w_sample),
    .o_done   (w_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_line  <= 1'b0;
      r_bf    <= 1'b0;
      r_polls <= '0;
      r_char  <= 4'd0;
      r_shift <= 16'd0;
      r_word  <= 16'd0;
      r_derr  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SET_ADDR;
            r_line  <= line_select;
            r_derr  <= 1'b0;
            r_tout  <= 1'b0;
            r_polls <= '0;
            r_char  <= 4'd0;
          end
        end
        SET_ADDR: begin
          if (w_done) begin
            r_state <= POLL_BF;
          end
        end
        POLL_BF: begin
          if (w_sample) begin
            r_bf <= lcd_data_in[7];
          end
          // The flag captured on the EN-high sample decides at cycle end.
          if (w_done) begin
            if (!r_bf) begin
              r_state <= READ_CHAR;
            end else if (r_polls == c_POLL_LAST) begin
              r_tout  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_polls <= r_polls + PCW'(1);
            end
          end
        end
        READ_CHAR: begin
          // Shifting in from the LSB leaves character k at bit 15-k.
          if (w_sample) begin
            r_shift <= {r_shift[14:0], w_char[0]};
            if (w_char[1]) begin
              r_derr <= 1'b1;
            end
          end
          if (w_done) begin
            if (r_char == 4'd15) begin
              r_state <= DONE;
              r_word  <= r_shift;
            end else begin
              r_char <= r_char + 4'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bus control is a pure decode of the state, so reset releases the bus
  // in the same instant it forces the controller back to IDLE.
  always_comb begin
    lcd_data_out = 8'h00;
    data_oe      = 1'b0;
    rs           = 1'b0;
    rw           = 1'b0;
    case (r_state)
      SET_ADDR: begin
        data_oe      = 1'b1;
        lcd_data_out = LCD_SET_DDRAM | (r_line ? LCD_LINE2_BASE : 8'h00);
      end
      POLL_BF: begin
        rw = 1'b1;
      end
      READ_CHAR: begin
        rs = 1'b1;
        rw = 1'b1;
      end
      default: begin
        lcd_data_out = 8'h00;
      end
    endcase
  end

  assign word_out     = r_word;
  assign word_valid   = (r_state == DONE);
  assign busy         = w_run;
  assign decode_error = r_derr;
  assign timeout      = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_read_from_lcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_from_lcd
// Description : Self-checking bench for read_from_lcd. A behavioural panel
//               answers busy-flag and character reads; expected words,
//               flags, command bytes and latencies come from tables and a
//               reference model of the line-decoding rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_read_from_lcd;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        line_select = 1'b0;
  logic [7:0]  lcd_data_in = 8'h00;

  logic [7:0]  lcd_data_out, lcd_data_out_t;
  logic        data_oe, data_oe_t, enable, enable_t, rs, rs_t, rw, rw_t;
  logic [15:0] word_out, word_out_t;
  logic        word_valid, word_valid_t, busy, busy_t;
  logic        decode_error, decode_error_t, timeout, timeout_t;

  always #5 clock = ~clock;

  read_from_lcd dut (
    .clock(clock), .reset(reset), .start(start), .line_select(line_select),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out),
    .data_oe(data_oe), .enable(enable), .rs(rs), .rw(rw),
    .word_out(word_out), .word_valid(word_valid), .busy(busy),
    .decode_error(decode_error), .timeout(timeout)
  );

  // Second instance with a short poll limit for the timeout boundary.
  read_from_lcd #(.BF_TIMEOUT(4)) dut_to (
    .clock(clock), .reset(reset), .start(start), .line_select(line_select),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out_t),
    .data_oe(data_oe_t), .enable(enable_t), .rs(rs_t), .rw(rw_t),
    .word_out(word_out_t), .word_valid(word_valid_t), .busy(busy_t),
    .decode_error(decode_error_t), .timeout(timeout_t)
  );

  int checks = 0;
  int failures = 0;

  // Panel state and bus observations
  logic [127:0] p_chars = '0;
  int  p_busy_left = 0;
  int  bf_reads = 0, char_reads = 0, cmd_count = 0, oe_errs = 0;
  int  wv_count = 0, wv_t_count = 0, to_polls = 0;
  logic [7:0] last_cmd = 8'h00;
  logic prev_en = 1'b0, prev_en_t = 1'b0;

  always @(negedge clock) begin
    if (enable && !prev_en) begin
      if (!rw) begin
        cmd_count++;
        last_cmd = lcd_data_out;
        if (!data_oe) oe_errs++;
      end else begin
        if (data_oe) oe_errs++;
        if (!rs) begin
          bf_reads++;
          if (p_busy_left > 0) begin
            lcd_data_in = {1'b1, 7'($urandom_range(0, 127))};
            p_busy_left--;
          end else begin
            lcd_data_in = {1'b0, 7'($urandom_range(0, 127))};
          end
        end else begin
          lcd_data_in = (char_reads < 16) ? p_chars[127 - 8*char_reads -: 8] : 8'h30;
          char_reads++;
        end
      end
    end
    if (!busy && data_oe) oe_errs++;
    if (word_valid) wv_count++;
    if (word_valid_t) wv_t_count++;
    if (enable_t && !prev_en_t && rw_t && !rs_t) to_polls++;
    prev_en   = enable;
    prev_en_t = enable_t;
  end

  typedef struct {
    logic         line;
    int           busy;
    logic [127:0] chars;
    logic [15:0]  exp_word;
    logic         exp_err;
    logic [7:0]   exp_cmd;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] outs_main();
    return {lcd_data_out, data_oe, enable, rs, rw, word_out, word_valid,
            busy, decode_error, timeout};
  endfunction

  function automatic logic [30:0] outs_to();
    return {lcd_data_out_t, data_oe_t, enable_t, rs_t, rw_t, word_out_t,
            word_valid_t, busy_t, decode_error_t, timeout_t};
  endfunction

  // Reference model: char k -> bit 15-k; '1'->1, '0'->0, other -> 0 + error.
  function automatic logic [16:0] model_line(input logic [127:0] chars);
    logic [15:0] w;
    logic        e;
    logic [7:0]  c;
    w = '0;
    e = 1'b0;
    for (int k = 0; k < 16; k++) begin
      c = chars[127 - 8*k -: 8];
      if (c == 8'h31) w[15 - k] = 1'b1;
      else if (c != 8'h30) e = 1'b1;
    end
    return {e, w};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || busy_t) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (busy || busy_t) chk("idle_wait_timeout", 32'(busy), 32'd0);
  endtask

  task automatic launch(input logic line, input int nbusy, input logic [127:0] chars);
    wait_idle();
    @(negedge clock);
    p_chars = chars; p_busy_left = nbusy;
    bf_reads = 0; char_reads = 0; cmd_count = 0; oe_errs = 0;
    wv_count = 0; wv_t_count = 0; to_polls = 0;
    line_select = line;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_txn(input logic line, input int nbusy, input logic [127:0] chars,
                         output int lat, output logic gv);
    launch(line, nbusy, chars);
    lat = 1;
    while (!word_valid && !timeout && lat < 5000) begin
      @(negedge clock);
      lat++;
    end
    gv = word_valid;
  endtask

  task automatic check_txn(input string name, input logic line, input int nbusy,
                           input logic [127:0] chars, input logic [15:0] exp_word,
                           input logic exp_err, input logic [7:0] exp_cmd);
    int   lat;
    logic gv;
    run_txn(line, nbusy, chars, lat, gv);
    chk({name, "_valid"}, 32'(gv), 32'd1);
    chk({name, "_word"}, 32'(word_out), 32'(exp_word));
    chk({name, "_derr"}, 32'(decode_error), 32'(exp_err));
    chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({name, "_latency"}, 32'(lat), 32'(73 + 4*nbusy));
    chk({name, "_cmd_count"}, 32'(cmd_count), 32'd1);
    chk({name, "_cmd_byte"}, 32'(last_cmd), 32'(exp_cmd));
    chk({name, "_bf_reads"}, 32'(bf_reads), 32'(nbusy + 1));
    chk({name, "_char_reads"}, 32'(char_reads), 32'd16);
    @(negedge clock);
    chk({name, "_valid_one_cycle"}, 32'(wv_count), 32'd1);
    chk({name, "_word_hold"}, 32'(word_out), 32'(exp_word));
    chk({name, "_oe_errs"}, 32'(oe_errs), 32'd0);
  endtask

  initial begin
    logic [15:0]  w0, w0t;
    logic [127:0] rc;
    logic [16:0]  m;
    logic         rl;
    int           rb, n;

    tbl[0] = '{1'b0, 0, "1010000011110001", 16'hA0F1, 1'b0, 8'h80};
    tbl[1] = '{1'b1, 5, "1111111111111111", 16'hFFFF, 1'b0, 8'hC0};
    tbl[2] = '{1'b0, 0, "11A1111111111111", 16'hDFFF, 1'b1, 8'h80};
    tbl[3] = '{1'b1, 2, "0000000000000000", 16'h0000, 1'b0, 8'hC0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'(outs_main()), 32'd0);
    chk("reset_outputs_to", 32'(outs_to()), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_outputs", 32'(outs_main()), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 4; i++) begin
      check_txn($sformatf("vec%0d", i), tbl[i].line, tbl[i].busy, tbl[i].chars,
                tbl[i].exp_word, tbl[i].exp_err, tbl[i].exp_cmd);
    end

    // Busy flag stuck high: short limit instance, then default limit
    w0 = word_out; w0t = word_out_t;
    launch(1'b0, 1000000, "0101010101010101");
    n = 0;
    while (!timeout_t && n < 200) begin @(negedge clock); n++; end
    chk("to_flag", 32'(timeout_t), 32'd1);
    chk("to_polls", 32'(to_polls), 32'd4);
    chk("to_busy", 32'(busy_t), 32'd0);
    chk("to_word_hold", 32'(word_out_t), 32'(w0t));
    chk("to_no_valid", 32'(wv_t_count), 32'd0);
    n = 0;
    while (!timeout && n < 1500) begin @(negedge clock); n++; end
    chk("to255_flag", 32'(timeout), 32'd1);
    chk("to255_polls", 32'(bf_reads), 32'd255);
    chk("to255_busy", 32'(busy), 32'd0);
    chk("to255_word_hold", 32'(word_out), 32'(w0));
    chk("to255_no_valid", 32'(wv_count), 32'd0);
    repeat (5) @(negedge clock);
    chk("to_sticky", 32'(timeout), 32'd1);

    // Start pulses while busy and in the DONE cycle are ignored
    launch(1'b0, 0, "1111000011110000");
    chk("t6_timeout_cleared", 32'(timeout), 32'd0);
    repeat (20) @(negedge clock);
    line_select = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!word_valid && n < 200) begin @(negedge clock); n++; end
    chk("t6_valid_seen", 32'(word_valid), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t6_busy_after_done", 32'(busy), 32'd0);
    repeat (100) @(negedge clock);
    chk("t6_cmd_count", 32'(cmd_count), 32'd1);
    chk("t6_cmd_byte", 32'(last_cmd), 32'h80);
    chk("t6_valid_count", 32'(wv_count), 32'd1);
    chk("t6_word", 32'(word_out), 32'hF0F0);

    // Reset in the middle of the 8th character read
    launch(1'b1, 0, "1111111100000000");
    n = 0;
    while (char_reads < 8 && n < 300) begin @(negedge clock); n++; end
    reset = 1'b0;
    #1;
    chk("t5_reset_outputs", 32'(outs_main()), 32'd0);
    chk("t5_reset_outputs_to", 32'(outs_to()), 32'd0);
    repeat (2) @(negedge clock);
    chk("t5_reset_held", 32'(outs_main()), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_txn("t5_after", 1'b0, 1, "0110100110010110", 16'h6996, 1'b0, 8'h80);

    // Randomized transactions against the reference model
    for (int it = 0; it < 8; it++) begin
      rl = 1'($urandom_range(0, 1));
      rb = int'($urandom_range(0, 6));
      for (int k = 0; k < 16; k++) begin
        n = int'($urandom_range(0, 9));
        rc[127 - 8*k -: 8] = (n < 5) ? 8'h30 : (n < 9) ? 8'h31 : 8'($urandom_range(0, 255));
      end
      m = model_line(rc);
      check_txn($sformatf("rnd%0d", it), rl, rb, rc, m[15:0], m[16],
                rl ? 8'hC0 : 8'h80);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
